// File: rtl/abr_mem_zeroize_arb.sv
// abr_mem_zeroize_arb
// Upstream port arbiter for one single-port ABR memory bank. Merges two
// client request streams (A, B) and a hardware zeroize sweep onto a single
// memory port, and routes the 1-cycle-latency read data back to whichever
// client issued the read.
//
// Optional feature: define ABR_MEM_ARB_RR_EN to resolve A/B conflicts
// round-robin instead of with fixed priority (A over B).
module abr_mem_zeroize_arb #(
    parameter int  DEPTH  = 64,
    parameter int  DATA_W = 96,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              zeroize_i,
    input  logic              a_req_i,
    input  logic              a_we_i,
    input  logic [ADDR_W-1:0] a_addr_i,
    input  logic [DATA_W-1:0] a_wdata_i,
    input  logic              b_req_i,
    input  logic              b_we_i,
    input  logic [ADDR_W-1:0] b_addr_i,
    input  logic [DATA_W-1:0] b_wdata_i,
    output logic              a_gnt_o,
    output logic              b_gnt_o,
    output logic              a_rvalid_o,
    output logic              b_rvalid_o,
    output logic [DATA_W-1:0] a_rdata_o,
    output logic [DATA_W-1:0] b_rdata_o,
    output logic              mem_re_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              zeroize_busy_o,
    output logic              zeroize_done_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ZERO = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_A    = 2'd1,
        OWN_B    = 2'd2
    } owner_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] sweep_q, sweep_d;
    owner_e            owner_q, owner_d;

    logic canGrant;
    logic startZero;
    logic aPrio;
    logic aGnt;
    logic bGnt;

`ifdef ABR_MEM_ARB_RR_EN
    logic lastB_q, lastB_d;

    // Remember who was granted last; reset to B so that A wins the first conflict.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            lastB_q <= 1'b1;
        end else begin
            lastB_q <= lastB_d;
        end
    end

    // Any grant updates the history, conflict or not.
    always_comb begin
        lastB_d = lastB_q;
        if (aGnt) begin
            lastB_d = 1'b0;
        end else if (bGnt) begin
            lastB_d = 1'b1;
        end
    end

    assign aPrio = lastB_q;
`else
    assign aPrio = 1'b1;
`endif

    // Clients may only be granted in IDLE and only when no sweep is starting.
    always_comb begin
        startZero = (state_q == ST_IDLE) && zeroize_i;
        canGrant  = (state_q == ST_IDLE) && !zeroize_i;
        aGnt      = canGrant && a_req_i && (!b_req_i || aPrio);
        bGnt      = canGrant && b_req_i && !aGnt;
    end

    // Sequencing state, sweep address and the owner of the in-flight read.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state_q <= ST_IDLE;
            sweep_q <= '0;
            owner_q <= OWN_NONE;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
            owner_q <= owner_d;
        end
    end

    // Next-state logic and memory port drive; the sweep owns the port in ZERO.
    always_comb begin
        state_d     = state_q;
        sweep_d     = sweep_q;
        owner_d     = OWN_NONE;
        mem_re_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;

        case (state_q)
            ST_IDLE: begin
                if (zeroize_i) begin
                    state_d = ST_ZERO;
                    sweep_d = '0;
                end else if (aGnt) begin
                    mem_we_o   = a_we_i;
                    mem_re_o   = !a_we_i;
                    mem_addr_o = a_addr_i;
                    if (a_we_i) begin
                        mem_wdata_o = a_wdata_i;
                    end else begin
                        owner_d = OWN_A;
                    end
                end else if (bGnt) begin
                    mem_we_o   = b_we_i;
                    mem_re_o   = !b_we_i;
                    mem_addr_o = b_addr_i;
                    if (b_we_i) begin
                        mem_wdata_o = b_wdata_i;
                    end else begin
                        owner_d = OWN_B;
                    end
                end
            end
            ST_ZERO: begin
                mem_we_o   = 1'b1;
                mem_addr_o = sweep_q;
                if (sweep_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = ST_DONE;
                    sweep_d = '0;
                end else begin
                    sweep_d = sweep_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                sweep_d = '0;
            end
        endcase
    end

    // Read return: the owner sees its data one cycle after the grant, unless a
    // sweep is being accepted that cycle, in which case the data is withheld.
    always_comb begin
        a_gnt_o        = aGnt;
        b_gnt_o        = bGnt;
        a_rvalid_o     = (owner_q == OWN_A) && !startZero;
        b_rvalid_o     = (owner_q == OWN_B) && !startZero;
        a_rdata_o      = a_rvalid_o ? mem_rdata_i : '0;
        b_rdata_o      = b_rvalid_o ? mem_rdata_i : '0;
        zeroize_busy_o = (state_q == ST_ZERO) || (state_q == ST_DONE);
        zeroize_done_o = (state_q == ST_DONE);
    end

endmodule
